// File: rtl/inst_encoder.sv
// ---------------------------------------------------------------------------
// inst_encoder
//
// Turns decoded RV32IM instruction fields into 32-bit instruction words. It is
// the exact inverse of the core's decoder: the same immediate ranges and
// sub-opcode legality rules apply, and a request that breaks any of them is
// accepted but produces no word. The LI pseudo-op expands into one or two
// words (ADDI, or LUI followed by an optional ADDI).
//
// Ports
//   clk, reset          single clock; synchronous active-high reset
//   in_valid/in_ready   request handshake
//   in_cls              instruction class (0 R, 1 I-ALU, 2 LOAD, 3 STORE,
//                       4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 CSR,
//                       10 PRIV, 11 LI; 12-15 illegal)
//   in_rd/in_rs1/in_rs2 register fields (in_rs1 is the uimm for CSR imm forms)
//   in_imm              full immediate / CSR address / ECALL-EBREAK code
//   in_alu_opc          {func1, func3} for R-type and I-ALU
//   in_func3            sub-opcode for LOAD, STORE, BRANCH, CSR
//   in_m32              R-type is an M-extension op
//   out_valid/out_ready output handshake, out_inst carries the word
//   err_pulse           one-cycle flag for a rejected request
//   err_sticky          any rejection since reset
//   inst_count          words consumed, wrapping 16-bit counter
// ---------------------------------------------------------------------------
module inst_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_cls,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    input  logic [3:0]  in_alu_opc,
    input  logic [2:0]  in_func3,
    input  logic        in_m32,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        err_pulse,
    output logic        err_sticky,
    output logic [15:0] inst_count
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_EXPAND = 1'b1;

    localparam logic [3:0] CLS_R     = 4'd0;
    localparam logic [3:0] CLS_IALU  = 4'd1;
    localparam logic [3:0] CLS_LOAD  = 4'd2;
    localparam logic [3:0] CLS_STORE = 4'd3;
    localparam logic [3:0] CLS_BR    = 4'd4;
    localparam logic [3:0] CLS_JAL   = 4'd5;
    localparam logic [3:0] CLS_JALR  = 4'd6;
    localparam logic [3:0] CLS_LUI   = 4'd7;
    localparam logic [3:0] CLS_AUIPC = 4'd8;
    localparam logic [3:0] CLS_CSR   = 4'd9;
    localparam logic [3:0] CLS_PRIV  = 4'd10;
    localparam logic [3:0] CLS_LI    = 4'd11;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BR     = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [0:0]  state;
    logic [31:0] pend_inst;

    logic        enc_legal;
    logic        enc_two;
    logic [31:0] enc_word0;
    logic [31:0] enc_word1;

    logic [2:0]  alu_f3;
    logic        alu_alt;
    logic        fits12;
    logic        fits13;
    logic        fits21;
    logic [19:0] li_hi;
    logic        in_fire;
    logic        out_fire;

    assign alu_f3  = in_alu_opc[2:0];
    assign alu_alt = in_alu_opc[3];

    // Sign-representable checks: every bit above the sign bit must copy it.
    assign fits12 = (in_imm[31:11] == {21{in_imm[11]}});
    assign fits13 = (in_imm[31:12] == {20{in_imm[12]}});
    assign fits21 = (in_imm[31:20] == {12{in_imm[20]}});

    // Upper part of LI: (imm + 0x800) >> 12. The carry out of the low 12 bits
    // is exactly imm[11], so the low half never has to be added.
    assign li_hi = in_imm[31:12] + {19'd0, in_imm[11]};

    assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // NOTE: every output of this block gets a default on entry so that no
    // class/branch combination can leave a value unassigned and infer a latch.
    always_comb begin
        enc_legal = 1'b0;
        enc_two   = 1'b0;
        enc_word0 = 32'd0;
        enc_word1 = 32'd0;
        case (in_cls)
            CLS_R: begin
                // The alternate func7 bit only exists for ADD/SUB and SRL/SRA.
                enc_legal = !(alu_alt && (in_m32 || (alu_f3 != 3'b000 && alu_f3 != 3'b101)));
                enc_word0 = {(in_m32 ? 7'b0000001 : {1'b0, alu_alt, 5'b00000}),
                             in_rs2, in_rs1, alu_f3, in_rd, OP_R};
            end
            CLS_IALU: begin
                if (alu_f3 == 3'b001 || alu_f3 == 3'b101) begin
                    enc_legal = (in_imm[31:5] == 27'd0);
                    enc_word0 = {1'b0, alu_alt, 5'b00000, in_imm[4:0],
                                 in_rs1, alu_f3, in_rd, OP_IMM};
                end else begin
                    enc_legal = !alu_alt && fits12;
                    enc_word0 = {in_imm[11:0], in_rs1, alu_f3, in_rd, OP_IMM};
                end
            end
            CLS_LOAD: begin
                enc_legal = fits12 && (in_func3 != 3'd3) && (in_func3[2:1] != 2'b11);
                enc_word0 = {in_imm[11:0], in_rs1, in_func3, in_rd, OP_LOAD};
            end
            CLS_STORE: begin
                enc_legal = fits12 && (in_func3 < 3'd3);
                enc_word0 = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], OP_STORE};
            end
            CLS_BR: begin
                enc_legal = fits13 && !in_imm[0] && (in_func3[2:1] != 2'b01);
                enc_word0 = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                             in_imm[4:1], in_imm[11], OP_BR};
            end
            CLS_JAL: begin
                enc_legal = fits21 && !in_imm[0];
                enc_word0 = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                             in_rd, OP_JAL};
            end
            CLS_JALR: begin
                enc_legal = fits12;
                enc_word0 = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
            end
            CLS_LUI: begin
                enc_legal = (in_imm[11:0] == 12'd0);
                enc_word0 = {in_imm[31:12], in_rd, OP_LUI};
            end
            CLS_AUIPC: begin
                enc_legal = (in_imm[11:0] == 12'd0);
                enc_word0 = {in_imm[31:12], in_rd, OP_AUIPC};
            end
            CLS_CSR: begin
                enc_legal = (in_imm[31:12] == 20'd0) && (in_func3[1:0] != 2'b00);
                enc_word0 = {in_imm[11:0], in_rs1, in_func3, in_rd, OP_SYSTEM};
            end
            CLS_PRIV: begin
                // ECALL is imm 0, EBREAK is imm 1; both sit in the funct12 field.
                enc_legal = (in_imm[31:1] == 31'd0);
                enc_word0 = {11'd0, in_imm[0], 5'd0, 3'b000, 5'd0, OP_SYSTEM};
            end
            CLS_LI: begin
                enc_legal = 1'b1;
                if (fits12) begin
                    enc_word0 = {in_imm[11:0], 5'd0, 3'b000, in_rd, OP_IMM};
                end else begin
                    enc_word0 = {li_hi, in_rd, OP_LUI};
                    enc_two   = (in_imm[11:0] != 12'd0);
                    enc_word1 = {in_imm[11:0], in_rd, 3'b000, in_rd, OP_IMM};
                end
            end
            default: begin
                enc_legal = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; later assignments in the block override
    // earlier ones (e.g. a new word overrides the consume-clear of out_valid).
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            out_valid  <= 1'b0;
            out_inst   <= 32'd0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            inst_count <= 16'd0;
        end else begin
            err_pulse <= 1'b0;
            if (out_fire) begin
                out_valid  <= 1'b0;
                inst_count <= inst_count + 16'd1;
            end
            if (state == ST_IDLE) begin
                if (in_fire) begin
                    if (enc_legal) begin
                        out_valid <= 1'b1;
                        out_inst  <= enc_word0;
                        if (enc_two) begin
                            state <= ST_EXPAND;
                        end
                    end else begin
                        err_pulse  <= 1'b1;
                        err_sticky <= 1'b1;
                    end
                end
            end else begin
                // The LUI half is always on the output here; release the ADDI
                // as soon as it is taken.
                if (out_fire) begin
                    out_valid <= 1'b1;
                    out_inst  <= pend_inst;
                    state     <= ST_IDLE;
                end
            end
        end
    end

    // NOTE: pend_inst has no reset: it is written on every accept that enters
    // ST_EXPAND and only read in that state, so its reset value is never seen.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && in_fire && enc_legal && enc_two) begin
            pend_inst <= enc_word1;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// ---------------------------------------------------------------------------
// tb_inst_encoder
//
// Directed scenarios plus randomized requests for inst_encoder. A reference
// model computes expected words from the field layouts with plain arithmetic;
// the driver pushes expectations into a queue when a request is accepted and
// an independent monitor pops and compares on every output handshake.
// ---------------------------------------------------------------------------
module tb_inst_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cls;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic [3:0]  in_alu_opc;
    logic [2:0]  in_func3;
    logic        in_m32;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        err_pulse;
    logic        err_sticky;
    logic [15:0] inst_count;

    inst_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cls     (in_cls),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .in_alu_opc (in_alu_opc),
        .in_func3   (in_func3),
        .in_m32     (in_m32),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .inst_count (inst_count)
    );

    typedef struct {
        logic [3:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [3:0]  alu_opc;
        logic [2:0]  func3;
        logic        m32;
    } req_t;

    int          checks;
    int          errors;
    int          cyc;
    int          ready_mode;   // 0 hold low, 1 hold high, 2 random
    int          exp_err;
    logic [31:0] exp_q[$];
    int          consume_cyc[$];
    logic [15:0] model_count;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit fits(input logic [31:0] v, input int bits);
        longint s;
        longint lim;
        s   = longint'($signed(v));
        lim = longint'(1) << (bits - 1);
        return (s >= -lim) && (s < lim);
    endfunction

    function automatic logic [31:0] fld(input logic [31:0] v, input int lo, input int width);
        logic [63:0] mask;
        mask = (64'd1 << width) - 64'd1;
        return 32'((64'(v) >> lo) & mask);
    endfunction

    function automatic void model(input req_t r, output bit ok, output int n,
                                  output logic [31:0] w0, output logic [31:0] w1);
        logic [31:0] imm;
        logic [31:0] rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] af3;
        logic [31:0] f3;
        logic [31:0] lo12;
        logic [31:0] hi;
        bit          alt;
        imm  = r.imm;
        rd   = 32'(r.rd);
        rs1  = 32'(r.rs1);
        rs2  = 32'(r.rs2);
        af3  = 32'(r.alu_opc[2:0]);
        f3   = 32'(r.func3);
        alt  = r.alu_opc[3];
        lo12 = imm & 32'hFFF;
        ok = 1'b0;
        n  = 1;
        w0 = 32'd0;
        w1 = 32'd0;
        case (r.cls)
            4'd0: begin
                ok = !(alt && (r.m32 || !(af3 == 0 || af3 == 5)));
                w0 = ((r.m32 ? 32'd1 : (alt ? 32'd32 : 32'd0)) << 25) | (rs2 << 20) |
                     (rs1 << 15) | (af3 << 12) | (rd << 7) | 32'h33;
            end
            4'd1: begin
                if (af3 == 1 || af3 == 5) begin
                    ok = (imm < 32);
                    w0 = ((alt ? 32'd32 : 32'd0) << 25) | (fld(imm, 0, 5) << 20) |
                         (rs1 << 15) | (af3 << 12) | (rd << 7) | 32'h13;
                end else begin
                    ok = !alt && fits(imm, 12);
                    w0 = (lo12 << 20) | (rs1 << 15) | (af3 << 12) | (rd << 7) | 32'h13;
                end
            end
            4'd2: begin
                ok = fits(imm, 12) && !(f3 == 3 || f3 == 6 || f3 == 7);
                w0 = (lo12 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
            end
            4'd3: begin
                ok = fits(imm, 12) && (f3 < 3);
                w0 = (fld(imm, 5, 7) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
                     (fld(imm, 0, 5) << 7) | 32'h23;
            end
            4'd4: begin
                ok = fits(imm, 13) && (imm % 2 == 0) && f3 != 2 && f3 != 3;
                w0 = (fld(imm, 12, 1) << 31) | (fld(imm, 5, 6) << 25) | (rs2 << 20) |
                     (rs1 << 15) | (f3 << 12) | (fld(imm, 1, 4) << 8) |
                     (fld(imm, 11, 1) << 7) | 32'h63;
            end
            4'd5: begin
                ok = fits(imm, 21) && (imm % 2 == 0);
                w0 = (fld(imm, 20, 1) << 31) | (fld(imm, 1, 10) << 21) |
                     (fld(imm, 11, 1) << 20) | (fld(imm, 12, 8) << 12) | (rd << 7) | 32'h6F;
            end
            4'd6: begin
                ok = fits(imm, 12);
                w0 = (lo12 << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
            end
            4'd7: begin
                ok = (lo12 == 0);
                w0 = imm + rd * 128 + 32'h37;
            end
            4'd8: begin
                ok = (lo12 == 0);
                w0 = imm + rd * 128 + 32'h17;
            end
            4'd9: begin
                ok = (imm < 4096) && f3 != 0 && f3 != 4;
                w0 = (imm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h73;
            end
            4'd10: begin
                ok = (imm < 2);
                w0 = (imm << 20) | 32'h73;
            end
            4'd11: begin
                ok = 1'b1;
                if (fits(imm, 12)) begin
                    w0 = (lo12 << 20) | (rd << 7) | 32'h13;
                end else begin
                    hi = (imm + 32'h800) / 4096;
                    w0 = hi * 4096 + rd * 128 + 32'h37;
                    if (lo12 != 0) begin
                        n  = 2;
                        w1 = (lo12 << 20) | (rd << 15) | (rd << 7) | 32'h13;
                    end
                end
            end
            default: ok = 1'b0;
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [31:0] exp;
        model_count = 16'd0;
        exp_err     = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                exp_err     = 0;
                model_count = 16'd0;
            end else begin
                check("inst_count", 32'(inst_count), 32'(model_count));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", out_inst, 32'hxxxxxxxx);
                    end else begin
                        exp = exp_q.pop_front();
                        check("out_inst", out_inst, exp);
                    end
                    model_count = model_count + 16'd1;
                    consume_cyc.push_back(cyc);
                end
                if (err_pulse) begin
                    check("err_pulse_expected", 32'(exp_err > 0), 32'd1);
                    if (exp_err > 0) exp_err--;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue_exp(input req_t r, input bit ok, input int n,
                             input logic [31:0] w0, input logic [31:0] w1);
        int  waited;
        bit  accepted;
        in_cls     = r.cls;
        in_rd      = r.rd;
        in_rs1     = r.rs1;
        in_rs2     = r.rs2;
        in_imm     = r.imm;
        in_alu_opc = r.alu_opc;
        in_func3   = r.func3;
        in_m32     = r.m32;
        in_valid   = 1'b1;
        waited     = 0;
        accepted   = 1'b0;
        while (!accepted && waited < 200) begin
            @(negedge clk);
            if (in_ready) accepted = 1'b1;
            else waited++;
        end
        if (!accepted) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else if (ok) begin
            exp_q.push_back(w0);
            if (n == 2) exp_q.push_back(w1);
        end else begin
            exp_err++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic issue(input req_t r);
        bit          ok;
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        model(r, ok, n, w0, w1);
        issue_exp(r, ok, n, w0, w1);
    endtask

    function automatic req_t mk(input logic [3:0] cls, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input logic [3:0] opc,
                                input logic [2:0] f3, input logic m32);
        req_t r;
        r.cls = cls; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
        r.imm = imm; r.alu_opc = opc; r.func3 = f3; r.m32 = m32;
        return r;
    endfunction

    function automatic logic [31:0] rand_imm();
        int edges[16] = '{2047, 2048, -2048, -2049, 4095, 4096, 4094, -4096,
                          -4098, 1048574, 1048576, -1048576, -1048578, 31, 32, 4097};
        case ($urandom_range(0, 4))
            0:       return 32'($urandom_range(0, 60)) - 32'd30;
            1:       return 32'(edges[$urandom_range(0, 15)]);
            2:       return $urandom;
            3:       return $urandom & 32'hFFFFF000;
            default: return 32'($urandom_range(0, 2));
        endcase
    endfunction

    function automatic req_t rand_req();
        req_t r;
        if ($urandom_range(0, 19) == 0) r.cls = 4'(12 + $urandom_range(0, 3));
        else                            r.cls = 4'($urandom_range(0, 11));
        r.rd      = 5'($urandom);
        r.rs1     = 5'($urandom);
        r.rs2     = 5'($urandom);
        r.imm     = rand_imm();
        r.alu_opc = 4'($urandom);
        if ($urandom_range(0, 1) == 0) r.alu_opc[3] = 1'b0;
        r.func3   = 3'($urandom);
        r.m32     = 1'($urandom);
        return r;
    endfunction

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int waited;
        checks     = 0;
        errors     = 0;
        ready_mode = 0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_cls     = 4'd0;
        in_rd      = 5'd0;
        in_rs1     = 5'd0;
        in_rs2     = 5'd0;
        in_imm     = 32'd0;
        in_alu_opc = 4'd0;
        in_func3   = 3'd0;
        in_m32     = 1'b0;

        do_reset(3);
        @(negedge clk);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_out_inst",   out_inst,        32'd0);
        check("rst_err_pulse",  32'(err_pulse),  32'd0);
        check("rst_err_sticky", 32'(err_sticky), 32'd0);
        check("rst_inst_count", 32'(inst_count), 32'd0);
        check("rst_in_ready",   32'(in_ready),   32'd1);
        @(posedge clk); #1;
        ready_mode = 1;

        // Basic R-type: ADD x3, x1, x2
        issue_exp(mk(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 4'd0, 3'd0, 1'b0), 1'b1, 1, 32'h002081B3, 32'd0);
        check("add_out_valid", 32'(out_valid), 32'd1);
        check("add_out_inst",  out_inst,       32'h002081B3);
        idle(2);
        check("add_inst_count", 32'(inst_count), 32'd1);

        // LI expansions
        issue_exp(mk(4'd11, 5'd5, 5'd0, 5'd0, 32'h12345678, 4'd0, 3'd0, 1'b0), 1'b1, 2, 32'h123452B7, 32'h67828293);
        check("li2_in_ready_low", 32'(in_ready), 32'd0);
        check("li2_first_word",   out_inst,      32'h123452B7);
        issue_exp(mk(4'd11, 5'd1, 5'd0, 5'd0, 32'h00000FFF, 4'd0, 3'd0, 1'b0), 1'b1, 2, 32'h000010B7, 32'hFFF08093);
        check("li_fff_in_ready_low", 32'(in_ready), 32'd0);
        issue_exp(mk(4'd11, 5'd5, 5'd0, 5'd0, 32'h12345000, 4'd0, 3'd0, 1'b0), 1'b1, 1, 32'h123452B7, 32'd0);
        check("li1_in_ready_high", 32'(in_ready), 32'd1);
        idle(2);

        // Branch legal and misaligned
        issue_exp(mk(4'd4, 5'd0, 5'd1, 5'd2, 32'd8, 4'd0, 3'd0, 1'b0), 1'b1, 1, 32'h00208463, 32'd0);
        issue_exp(mk(4'd4, 5'd0, 5'd1, 5'd2, 32'd7, 4'd0, 3'd0, 1'b0), 1'b0, 0, 32'd0, 32'd0);
        check("rej_err_pulse",  32'(err_pulse),  32'd1);
        check("rej_err_sticky", 32'(err_sticky), 32'd1);
        check("rej_out_valid",  32'(out_valid),  32'd0);
        base = int'(model_count);
        idle(1);
        check("rej_err_pulse_once", 32'(err_pulse),  32'd0);
        check("rej_inst_count",     32'(inst_count), 32'(base));
        check("rej_sticky_holds",   32'(err_sticky), 32'd1);
        idle(2);

        // Backpressure: MUL x7, x4, x9 held for three cycles
        ready_mode = 0;
        issue_exp(mk(4'd0, 5'd7, 5'd4, 5'd9, 32'd0, 4'd0, 3'd0, 1'b1), 1'b1, 1, 32'h029203B3, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_inst",  out_inst,       32'h029203B3);
            check("bp_in_ready",  32'(in_ready),  32'd0);
        end
        @(posedge clk); #1;
        ready_mode = 1;
        idle(3);

        // Back-to-back stream of four R-type words
        do_reset(1);
        base = consume_cyc.size();
        for (int i = 0; i < 4; i++) begin
            issue(mk(4'd0, 5'($urandom), 5'($urandom), 5'($urandom), 32'd0,
                     4'($urandom_range(0, 7)), 3'd0, 1'b0));
        end
        idle(3);
        check("stream_words", 32'(consume_cyc.size() - base), 32'd4);
        if (consume_cyc.size() - base == 4)
            check("stream_consecutive", 32'(consume_cyc[base + 3] - consume_cyc[base]), 32'd3);
        check("stream_inst_count", 32'(inst_count), 32'd4);

        // Reset while the ADDI of an LI is pending
        ready_mode = 0;
        issue_exp(mk(4'd11, 5'd5, 5'd0, 5'd0, 32'h12345678, 4'd0, 3'd0, 1'b0), 1'b1, 2, 32'h123452B7, 32'h67828293);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mrst_out_valid",  32'(out_valid),  32'd0);
        check("mrst_out_inst",   out_inst,        32'd0);
        check("mrst_err_pulse",  32'(err_pulse),  32'd0);
        check("mrst_err_sticky", 32'(err_sticky), 32'd0);
        check("mrst_inst_count", 32'(inst_count), 32'd0);
        check("mrst_in_ready",   32'(in_ready),   32'd1);
        ready_mode = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mrst_no_word", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;

        // Randomized traffic with random backpressure
        ready_mode = 2;
        for (int i = 0; i < 400; i++) begin
            issue(rand_req());
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
        end

        // Drain
        ready_mode = 1;
        waited = 0;
        while ((exp_q.size() != 0 || exp_err != 0) && waited < 500) begin
            @(posedge clk);
            waited++;
        end
        idle(2);
        check("drain_words_left", 32'(exp_q.size()), 32'd0);
        check("drain_errs_left",  32'(exp_err),      32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Synchronous RV32IM instruction encoder: accepts decoded instruction fields over a valid/ready request port and emits 32-bit RV32IM instruction words over a valid/ready output port. Encoding, immediate-range checking and sub-opcode legality checking are the exact inverse of the core's instruction decoder. It also expands the `LI` pseudo-op into one or two words. It sits in front of the instruction-memory loader and the self-test program generator, and produces the words that the core's decoder consumes.

## Interface
- No parameters.
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: request present.
- `in_ready` output 1: request accepted when `in_valid && in_ready`.
- `in_cls` input 4: instruction class. 0 R-type, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 CSR, 10 PRIV, 11 LI. Codes 12-15 are illegal.
- `in_rd`, `in_rs1`, `in_rs2` input 5 each: register fields. For CSR immediate forms, `in_rs1` carries the uimm.
- `in_imm` input 32: immediate as a full signed or absolute value. For CSR it is the CSR address; for PRIV it is the ECALL/EBREAK code.
- `in_alu_opc` input 4: `{func1, func3}`, as produced by the decoder.
- `in_func3` input 3: sub-opcode for LOAD, STORE, BRANCH and CSR.
- `in_m32` input 1: R-type is an M-extension op.
- `out_valid` output 1: `out_inst` holds a word.
- `out_ready` input 1: word consumed when `out_valid && out_ready`.
- `out_inst` output 32: encoded instruction.
- `err_pulse` output 1: one-cycle flag that the accepted request was rejected.
- `err_sticky` output 1: set by any rejection; cleared only by reset.
- `inst_count` output 16: number of words consumed; wraps at 0xFFFF -> 0.

## Operation
**States**
- `ST_IDLE`: accepting requests.
- `ST_EXPAND`: second word of an `LI` is pending.

**Handshake**
- `in_ready = (state==ST_IDLE) && (!out_valid || out_ready)`.
- An accepted legal request loads the output register.

**Encoding and legality rules.** Any violation rejects the request.
- **R-type:**
  - func7 is `0000001` when `in_m32`; otherwise `{0, alu_opc[3], 00000}`.
  - `alu_opc[3]=1` is legal only for func3 000 or 101 with `in_m32=0`.
- **I-ALU:**
  - func3 001/101 (shifts): require `imm[31:5]==0`; inst[30] = `alu_opc[3]`.
  - Other func3: require `alu_opc[3]==0`, and `imm` must be sign-representable in 12 bits.
- **LOAD and JALR:**
  - 12-bit signed imm.
  - LOAD func3 3, 6 and 7 are illegal.
  - JALR func3 is forced to 000.
- **STORE:** 12-bit signed imm in S-format; func3 of 3 or more is illegal.
- **BRANCH:** 13-bit signed imm with `imm[0]==0`; func3 2 and 3 are illegal.
- **JAL:** 21-bit signed imm with `imm[0]==0`.
- **LUI and AUIPC:** require `imm[11:0]==0`; emit `imm[31:12]`.
- **CSR:**
  - func3 0 and 4 are illegal.
  - inst[31:20] = `imm[11:0]`, and `imm[31:12]` must be 0.
  - rs1 field = `in_rs1`.
- **PRIV:**
  - `imm` 0 encodes ECALL; `imm` 1 encodes EBREAK; any other value is illegal.
  - rd and rs1 fields are encoded as 0.
- **LI:**
  - If `imm` fits 12-bit signed: emit `ADDI rd, x0, imm`.
  - Else compute `hi = (imm + 0x800)[31:12]` (32-bit wrap) and emit `LUI rd, hi`.
  - If `imm[11:0] != 0`, then emit `ADDI rd, rd, sext(imm[11:0])`: enter `ST_EXPAND` with the ADDI word stored.
  - In `ST_EXPAND`, on `out_ready`, load the ADDI word and return to `ST_IDLE`.

**Rejection**
- The request is still accepted (`in_ready` handshake completes).
- No word is produced, `out_valid` is unchanged, and `inst_count` is unchanged.

## Timing
**Reset values**
- `out_valid` 0, `out_inst` 0, `err_pulse` 0, `err_sticky` 0, `inst_count` 0.
- State `ST_IDLE`, so `in_ready` is 1 after reset.

**Latency**
- A request accepted in cycle N gives `out_valid` in N+1, or `err_pulse` in N+1.
- Throughput is one word per cycle when `out_ready` is held high.
- A two-word `LI` occupies two output cycles; `in_ready` is low during `ST_EXPAND`.

**Backpressure**
- While `out_valid && !out_ready`, `out_inst` is held stable and `in_ready` is 0.
- A same-cycle output consume and input accept is allowed (back-to-back operation).

**Counter and error timing**
- `inst_count` increments in the cycle after each output handshake.
- `err_pulse` and the `err_sticky` set occur in the same cycle.

**Reset mid-operation**
- `reset` asserted in `ST_EXPAND` drops the pending ADDI, clears `out_valid`, and returns to `ST_IDLE`.

## Test plan
- R-type, rd=3, rs1=1, rs2=2, opc=0000 -> `out_inst` 0x002081B3 one cycle after accept; `inst_count` 1 after consume.
- `LI x5, 0x12345678` -> 0x123452B7 then 0x67828293; `in_ready` low between the two words. `LI x1, 0x00000FFF` -> 0x000010B7 then 0xFFF08093. `LI x5, 0x12345000` -> single word 0x123452B7.
- BRANCH func3=0, rs1=1, rs2=2, imm=8 -> 0x00208463. Same request with imm=7 -> no `out_valid`, `err_pulse` high for exactly 1 cycle, `err_sticky`=1, `inst_count` unchanged.
- Hold `out_ready` low for 3 cycles with `out_valid` set -> `out_inst` constant and `in_ready` 0 throughout; the word is consumed once `out_ready` goes high.
- Stream of 4 R-type requests with `out_ready` high -> 4 words on 4 consecutive cycles; `inst_count` equals 4.
- Issue `LI x5, 0x12345678` and assert `reset` while the ADDI is pending -> all outputs at reset values next cycle; `in_ready`=1; no further word emitted.
